// File: rtl/seq_divider_if.sv
// Handshake/result bundle for the sequential divider.
// The master drives the operands and start; the slave returns the results and status.
interface seq_divider_if #(
  parameter int DW = 12,
  parameter int VW = 6
);
  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          busy;
  logic          done;
  logic          dbz;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, dbz
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, dbz
  );
endinterface

// File: rtl/seq_divider.sv
// Restoring unsigned divider: one quotient bit per RUN cycle, DW cycles per operation.
// Results are copied to the output registers only when leaving FIN, so the outputs
// never show partial values while a division is running.
module seq_divider #(
  parameter int DW = 12,
  parameter int VW = 6
) (
  input  logic          clk,
  input  logic          rst,
  seq_divider_if.slave  bus
);

  localparam int             CW       = $clog2(DW + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DW - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [DW-1:0]  q_q, q_d;          // dividend shifting out / quotient shifting in
  logic [VW:0]    r_q, r_d;          // partial remainder, one guard bit wide
  logic [VW-1:0]  dvs_q, dvs_d;      // latched divisor
  logic [CW-1:0]  cnt_q, cnt_d;      // completed iterations
  logic [DW-1:0]  quo_q, quo_d;
  logic [VW-1:0]  rem_q, rem_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           dbz_q, dbz_d;

  logic [VW+1:0]  shift_s;           // {R,Q} shifted left, upper part only
  logic [VW+1:0]  trial_s;           // shifted R minus divisor; top bit set means negative

  // Trial subtraction for the current restoring step.
  always_comb begin
    shift_s = {r_q, q_q[DW-1]};
    trial_s = shift_s - {2'b00, dvs_q};
  end

  // Next-state and datapath update for the IDLE/RUN/FIN sequence.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    r_d     = r_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          dvs_d = bus.divisor;
          r_d   = {(VW+1){1'b0}};
          cnt_d = {CW{1'b0}};
          if (bus.divisor != {VW{1'b0}}) begin
            q_d     = bus.dividend;
            dbz_d   = 1'b0;
            state_d = RUN;
          end else begin
            // Divide by zero: saturated quotient, no iterations.
            q_d     = {DW{1'b1}};
            dbz_d   = 1'b1;
            state_d = FIN;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        cnt_d = cnt_q + CNT_ONE;
        if (!trial_s[VW+1]) begin
          r_d = trial_s[VW:0];
          q_d = {q_q[DW-2:0], 1'b1};
        end else begin
          r_d = shift_s[VW:0];
          q_d = {q_q[DW-2:0], 1'b0};
        end
        if (cnt_q == CNT_LAST) begin
          state_d = FIN;
        end else begin
          state_d = RUN;
        end
      end
      FIN: begin
        quo_d   = q_q;
        rem_d   = r_q[VW-1:0];
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      q_q     <= {DW{1'b0}};
      r_q     <= {(VW+1){1'b0}};
      dvs_q   <= {VW{1'b0}};
      cnt_q   <= {CW{1'b0}};
      quo_q   <= {DW{1'b0}};
      rem_q   <= {VW{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.quotient  = quo_q;
  assign bus.remainder = rem_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.dbz       = dbz_q;

endmodule
